// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// fill level, programmable almost-full/almost-empty, flush and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic                       flush_i,
    input  logic                       clr_err_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;
    logic ovf_evt;
    logic unf_evt;

    // Status is decoded from the registered count only, so it never depends on we_i/re_i.
    assign full_w         = (count_q == FULL_LVL);
    assign empty_w        = (count_q == '0);
    assign full_o         = full_w;
    assign empty_o        = empty_w;
    assign almost_full_o  = (count_q >= AF_LVL);
    assign almost_empty_o = (count_q <= AE_LVL);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // A flush cycle swallows any request without acting on it or flagging it.
    assign wr_acc  = we_i & (~full_w | re_i) & ~flush_i;
    assign rd_acc  = re_i & ~empty_w & ~flush_i;
    assign ovf_evt = we_i & full_w & ~re_i & ~flush_i;
    assign unf_evt = re_i & empty_w & ~flush_i;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A new error in the same cycle as a clear leaves the flag set.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end
        if (unf_evt) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wptr_q] <= data_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_o = mem[rptr_q];
        end else begin : g_std
            logic [WIDTH-1:0] data_q;

            // On full with simultaneous write, this still captures the old head.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rptr_q];
                end
            end

            assign data_o = data_q;
        end
    endgenerate

endmodule
